// File: rtl/arb2_stream_sel.sv
// ---------------------------------------------------------------------------
// arb2_stream_sel
//   Two-input round-robin valid/ready arbiter with a registered output stage.
//   The arbiter registers the winning beat on out_data. sel records which
//   source that beat came from and drives the select of the downstream 2:1
//   mux. A saturating burst counter lets the current owner keep the grant
//   for up to MAX_BURST consecutive beats while the other source is also
//   requesting.
//
// Parameters
//   WIDTH      data width of each input channel and of out_data
//   MAX_BURST  beats one source may take in a row under contention (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in0_data   source 0 beat          in0_valid / in0_ready  source 0 handshake
//   in1_data   source 1 beat          in1_valid / in1_ready  source 1 handshake
//   out_data   registered winning beat
//   out_valid  out_data holds a beat  out_ready  downstream consumes it
//   sel        source index of the beat in out_data (0 = in0, 1 = in1)
// ---------------------------------------------------------------------------
module arb2_stream_sel #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sel
);

  localparam int             CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             load;
  logic             winner;

  // Saturating increment: the burst count stops at MAX_BURST, never wraps.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (c >= CNT_MAX) return CNT_MAX;
    return c + CW'(1);
  endfunction

  // ---- arbitration (combinational) ----
  assign accept = !out_valid_q || out_ready;
  assign load   = accept && (in0_valid || in1_valid);

  always_comb begin
    winner = 1'b0;
    case ({in1_valid, in0_valid})
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      // Under contention the owner keeps the grant until its burst is used up.
      2'b11:   winner = (cnt_q < CNT_MAX) ? last_q : ~last_q;
      default: winner = 1'b0;
    endcase
  end

  // Readies depend only on valids and output state, so no ready->valid loop.
  assign in0_ready = accept && in0_valid && (winner == 1'b0);
  assign in1_ready = accept && in1_valid && (winner == 1'b1);

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sel_d       = sel_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    if (load) begin
      // A consume in the same cycle is absorbed here: the new beat simply
      // overwrites the old one, keeping one beat per cycle.
      out_data_d  = winner ? in1_data : in0_data;
      sel_d       = winner;
      out_valid_d = 1'b1;
      if (winner == last_q) begin
        cnt_d = sat_inc(cnt_q);
      end else begin
        last_d = winner;
        cnt_d  = CW'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ---- output register stage ----
  // Reset state gives last=1 with a full burst count, so the first tie goes to in0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= CNT_MAX;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sel       = sel_q;

endmodule

// File: doc/arb2_stream_sel.md
Name: arb2_stream_sel

Overview:
- Two-input round-robin stream arbiter with a registered output stage.
- Sits directly upstream of the 2:1 gate-level mux.
- Each cycle it picks one of two valid/ready sources and registers that beat. `sel` drives the downstream mux select; `out_data` carries the chosen beat.
- A burst counter lets one source keep the grant for up to MAX_BURST consecutive beats before the other source must be served.

Parameters:
WIDTH  8  data width of each input channel and out_data
MAX_BURST  1  maximum consecutive beats granted to one source while the other is also requesting (legal >= 1; 1 = strict alternation)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in0_data  input  WIDTH  source 0 data
in0_valid  input  1  source 0 has a beat
in0_ready  output  1  source 0 beat accepted this cycle
in1_data  input  WIDTH  source 1 data
in1_valid  input  1  source 1 has a beat
in1_ready  output  1  source 1 beat accepted this cycle
out_data  output  WIDTH  registered winning beat
out_valid  output  1  out_data holds a beat
out_ready  input  1  downstream consumes beat
sel  output  1  source index of beat in out_data (0 = in0, 1 = in1); feeds mux select

Behaviour:
- Reset (rst_n low, async assert, sync-to-clk deassert seen by logic):
  - out_valid=0, out_data=0, sel=0.
  - Internal last=1, burst_cnt=MAX_BURST, so the first tie goes to in0.
- Load enable: `accept = !out_valid || out_ready` (combinational). The register loads when accept is high and at least one input is valid.
- Winner, combinational:
  - Only in0_valid -> 0.
  - Only in1_valid -> 1.
  - Both valid -> last if burst_cnt < MAX_BURST, else ~last.
- Readies, combinational from valids (no loop; inputs must not depend on ready):
  - `in0_ready = accept && in0_valid && winner==0`
  - `in1_ready = accept && in1_valid && winner==1`
  - At most one ready is high per cycle.
- On load:
  - out_data <= winning data; sel <= winner; out_valid <= 1.
  - If winner==last, burst_cnt <= min(burst_cnt+1, MAX_BURST); else last <= winner and burst_cnt <= 1.
- On `out_valid && out_ready` with no load: out_valid <= 0. out_data and sel hold their last values.
- Simultaneous consume and load: the new beat replaces the old in the same edge, giving full throughput of 1 beat/cycle with no bubble.
- Stall: out_valid=1 and out_ready=0 -> both readies 0. out_data, sel, last and burst_cnt all hold.
- Latency: an accepted beat appears on out_data/out_valid 1 cycle after its handshake.
- Single requester: it is granted every cycle regardless of burst_cnt. Its count still advances and saturates at MAX_BURST.
- burst_cnt width: `$clog2(MAX_BURST+1)`, saturating, never wraps.
- Reset mid-operation: the in-flight out_data beat is dropped (out_valid=0 immediately), and arbitration state returns to reset values.
- sel changes only on a load edge; it is stable while out_valid is held.

Test Plan:
1. Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, sel=0, out_data=0 without waiting for clk. After release with in0_valid=in1_valid=1 (in0=0x11, in1=0x22) and out_ready=1 -> first out beat 0x11, sel=0.
2. Alternation, MAX_BURST=1, both valid, out_ready=1 for 6 cycles: in0 presents 0x10..0x12 and in1 presents 0x20..0x22 (each advancing on its ready) -> out sequence 0x10,0x20,0x11,0x21,0x12,0x22; sel 0,1,0,1,0,1; one beat per cycle.
3. Burst, MAX_BURST=3, both continuously valid -> sel pattern 0,0,0,1,1,1,0 and exactly 3 in0_ready pulses before the first in1_ready.
4. Single source: only in1_valid for 5 cycles -> in1_ready=1 every cycle and sel=1 every beat. When in0_valid then rises with in1 still valid -> in0 wins next, since burst_cnt is saturated.
5. Backpressure: out_ready=0 for 4 cycles with both valid -> in0_ready=in1_ready=0 and out_data/sel constant. out_ready=1 on cycle 5 -> the next beat loads on that edge and arbitration resumes from the saved last/burst_cnt.
6. Drain: inputs go idle while out_valid=1, then out_ready=1 -> out_valid falls next edge and sel holds its last value.
